// File: rtl/mux_4to1_scanner.sv
// Scan sequencer for a 4-to-1 mux. It walks the enabled channels in ascending order,
// holds each one for DWELL cycles, and captures y into sample on the last dwell cycle.
module mux_4to1_scanner #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       y,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] sample,
  output logic       done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       mask_q, mask_n;
  logic [1:0]       sel_n;
  logic             busy_n;
  logic [3:0]       sample_n;
  logic             done_n;

  logic [1:0]       first_ch;
  logic [1:0]       next_ch;
  logic             has_next;

  // Lowest enabled channel of the incoming mask.
  always_comb begin
    first_ch = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (mask[n]) first_ch = 2'(n);
    end
  end

  // Lowest enabled channel strictly above the current selection. No wrap-around.
  always_comb begin
    has_next = 1'b0;
    next_ch  = sel;
    for (int n = 3; n >= 0; n--) begin
      if (mask_q[n] && (n > int'(sel))) begin
        has_next = 1'b1;
        next_ch  = 2'(n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mask_q <= 4'b0000;
      sel    <= 2'd0;
      busy   <= 1'b0;
      sample <= 4'b0000;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mask_q <= mask_n;
      sel    <= sel_n;
      busy   <= busy_n;
      sample <= sample_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mask_n   = mask_q;
    sel_n    = sel;
    busy_n   = busy;
    sample_n = sample;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sample_n = 4'b0000;
          if (mask != 4'b0000) begin
            mask_n  = mask;
            sel_n   = first_ch;
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = SCAN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SCAN: begin
        if (cnt == LAST) begin
          sample_n[sel] = y;
          cnt_n         = '0;
          if (has_next) begin
            sel_n = next_ch;
          end else begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_4to1_scanner.sv
// Directed bench for mux_4to1_scanner: a DWELL=4 instance and a DWELL=1 instance,
// each feeding an ideal combinational 4-to-1 mux back into y.
module tb_mux_4to1_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start1;
  logic [3:0] mask4, mask1;
  logic [3:0] i4, i1;
  logic       y4, y1;
  logic [1:0] sel4, sel1;
  logic       busy4, busy1, done4, done1;
  logic [3:0] sample4, sample1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y4 = i4[sel4];
  assign y1 = i1[sel1];

  mux_4to1_scanner #(.DWELL(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start4), .mask(mask4), .y(y4),
    .sel(sel4), .busy(busy4), .sample(sample4), .done(done4)
  );

  mux_4to1_scanner #(.DWELL(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mask(mask1), .y(y1),
    .sel(sel1), .busy(busy1), .sample(sample1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      start4 = 1'($urandom_range(0, 1));
      mask4  = 4'($urandom_range(0, 15));
      start1 = 1'($urandom_range(0, 1));
      mask1  = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if ({sel4, busy4, done4, sample4} !== 8'b00_0_0_0000) begin
        errors++;
        $display("FAIL reset4 c=%0d got %b exp %b", c, {sel4, busy4, done4, sample4}, 8'b0);
      end
      checks++;
      if ({sel1, busy1, done1, sample1} !== 8'b00_0_0_0000) begin
        errors++;
        $display("FAIL reset1 c=%0d got %b exp %b", c, {sel1, busy1, done1, sample1}, 8'b0);
      end
    end
    rst = 1'b0; start4 = 1'b0; start1 = 1'b0; mask4 = 4'b0; mask1 = 4'b0;
    tick();
  endtask

  // mask=1111, i=1010; optionally a start with mask=0001 sampled at edge k+5.
  task automatic test_full_scan(input bit inject);
    logic [3:0] exp_s;
    logic [1:0] exp_sel;
    i4 = 4'b1010; mask4 = 4'b1111; start4 = 1'b1;
    tick();
    start4 = 1'b0; mask4 = 4'b0000;
    exp_s = 4'b0000;
    checks++;
    if ({sel4, busy4, done4, sample4} !== {2'd0, 1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL full_start inj=%0d got %b exp %b", inject, {sel4, busy4, done4, sample4}, 8'b00_1_0_0000);
    end
    for (int e = 1; e <= 16; e++) begin
      if (inject && e == 5) begin
        start4 = 1'b1; mask4 = 4'b0001;
      end
      tick();
      start4 = 1'b0; mask4 = 4'b0000;
      if (e % 4 == 0) exp_s[e/4-1] = i4[e/4-1];
      exp_sel = (e == 16) ? 2'd3 : 2'(e / 4);
      checks++;
      if ({sel4, busy4, done4, sample4} !== {exp_sel, (e != 16), (e == 16), exp_s}) begin
        errors++;
        $display("FAIL full_scan inj=%0d e=%0d got %b exp %b", inject, e,
                 {sel4, busy4, done4, sample4}, {exp_sel, (e != 16), (e == 16), exp_s});
      end
    end
    tick();
    checks++;
    if ({sel4, busy4, done4, sample4} !== {2'd3, 1'b0, 1'b0, 4'b1010}) begin
      errors++;
      $display("FAIL full_after inj=%0d got %b exp %b", inject, {sel4, busy4, done4, sample4}, 8'b11_0_0_1010);
    end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_sel;
    i4 = 4'b1111; mask4 = 4'b0101; start4 = 1'b1;
    tick();
    start4 = 1'b0; mask4 = 4'b0000;
    for (int e = 0; e <= 8; e++) begin
      if (e > 0) tick();
      exp_sel = (e < 4) ? 2'd0 : 2'd2;
      checks++;
      if ({sel4, busy4, done4} !== {exp_sel, (e != 8), (e == 8)}) begin
        errors++;
        $display("FAIL sparse e=%0d got %b exp %b", e, {sel4, busy4, done4}, {exp_sel, (e != 8), (e == 8)});
      end
    end
    checks++;
    if (sample4 !== 4'b0101) begin
      errors++;
      $display("FAIL sparse_sample got %b exp %b", sample4, 4'b0101);
    end
  endtask

  task automatic test_empty();
    mask4 = 4'b0000; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if ({busy4, done4, sample4} !== {1'b0, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL empty_done got %b exp %b", {busy4, done4, sample4}, 6'b0_1_0000);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({busy4, done4, sample4} !== 6'b0_0_0000) begin
        errors++;
        $display("FAIL empty_after c=%0d got %b exp %b", c, {busy4, done4, sample4}, 6'b0);
      end
    end
  endtask

  task automatic test_reset_mid();
    i4 = 4'b1010; mask4 = 4'b1111; start4 = 1'b1;
    tick();
    start4 = 1'b0; mask4 = 4'b0000;
    for (int e = 1; e <= 6; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({sel4, busy4, done4, sample4} !== 8'b00_0_0_0000) begin
      errors++;
      $display("FAIL reset_mid got %b exp %b", {sel4, busy4, done4, sample4}, 8'b0);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({busy4, done4} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_quiet c=%0d got %b exp %b", c, {busy4, done4}, 2'b00);
      end
    end
  endtask

  task automatic test_min_dwell();
    i1 = 4'b1000; mask1 = 4'b1001; start1 = 1'b1;
    tick();
    start1 = 1'b0; mask1 = 4'b0000;
    checks++;
    if ({sel1, busy1, done1, sample1} !== {2'd0, 1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL min_k got %b exp %b", {sel1, busy1, done1, sample1}, 8'b00_1_0_0000);
    end
    tick();
    checks++;
    if ({sel1, busy1, done1, sample1} !== {2'd3, 1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL min_k1 got %b exp %b", {sel1, busy1, done1, sample1}, 8'b11_1_0_0000);
    end
    tick();
    checks++;
    if ({sel1, busy1, done1, sample1} !== {2'd3, 1'b0, 1'b1, 4'b1000}) begin
      errors++;
      $display("FAIL min_k2 got %b exp %b", {sel1, busy1, done1, sample1}, 8'b11_0_1_1000);
    end
    tick();
    checks++;
    if ({busy1, done1, sample1} !== {1'b0, 1'b0, 4'b1000}) begin
      errors++;
      $display("FAIL min_k3 got %b exp %b", {busy1, done1, sample1}, 6'b0_0_1000);
    end
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
    mask4 = 4'b0; mask1 = 4'b0; i4 = 4'b0; i1 = 4'b0;
    test_reset();
    test_full_scan(1'b0);
    test_sparse();
    test_empty();
    test_full_scan(1'b1);
    test_reset_mid();
    test_full_scan(1'b0);
    test_min_dwell();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
